interrupt_ack_eoi_ctrl: RTL



---
 rtl/pic_pkg.sv | 41 ++++
 rtl/pic_ocw2_decoder.sv | 48 ++++
 rtl/interrupt_ack_eoi_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types, OCW2 command codes and level/one-hot helpers for the 8259
// interrupt acknowledge and end-of-interrupt control path.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2,
        ST_ACK3 = 2'd3
    } ack_state_t;

    // OCW2 commands, indexed by {R, SL, EOI}
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    localparam logic [2:0] PRIORITY_ROTATE_RESET = 3'b111;
    localparam logic [2:0] SPURIOUS_LEVEL        = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] level);
        onehot8 = 8'd1 << level;
    endfunction

    // Returns the index of the set bit; an all-zero input yields level 0.
    function automatic logic [2:0] encode8(input logic [7:0] onehot);
        encode8 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                encode8 = 3'(i);
            end else begin
                encode8 = encode8;
            end
        end
    endfunction

endpackage

// File: rtl/pic_ocw2_decoder.sv
// Combinational OCW2 decode: turns a written command byte into EOI-type,
// rotate-source and rotate-on-AEOI control flags.
module pic_ocw2_decoder
    import pic_pkg::*;
(
    input  logic       write_ocw2,
    input  logic [7:0] ocw2_data,
    output logic       eoi_nonspecific,
    output logic       eoi_specific,
    output logic       rotate_from_isr,
    output logic       rotate_from_level,
    output logic       rot_aeoi_set,
    output logic       rot_aeoi_clr,
    output logic [2:0] level
);

    logic [2:0] cmd_s;

    // Without a write strobe the command collapses to the no-op code.
    always_comb begin
        cmd_s             = write_ocw2 ? ocw2_data[7:5] : OCW2_NOP;
        level             = ocw2_data[2:0];
        eoi_nonspecific   = 1'b0;
        eoi_specific      = 1'b0;
        rotate_from_isr   = 1'b0;
        rotate_from_level = 1'b0;
        rot_aeoi_set      = 1'b0;
        rot_aeoi_clr      = 1'b0;
        case (cmd_s)
            OCW2_ROT_AEOI_CLR: rot_aeoi_clr = 1'b1;
            OCW2_NS_EOI:       eoi_nonspecific = 1'b1;
            OCW2_NOP:          eoi_nonspecific = 1'b0;
            OCW2_SP_EOI:       eoi_specific = 1'b1;
            OCW2_ROT_AEOI_SET: rot_aeoi_set = 1'b1;
            OCW2_ROT_NS_EOI: begin
                eoi_nonspecific = 1'b1;
                rotate_from_isr = 1'b1;
            end
            OCW2_SET_PRIO:     rotate_from_level = 1'b1;
            OCW2_ROT_SP_EOI: begin
                eoi_specific      = 1'b1;
                rotate_from_level = 1'b1;
            end
            default:           eoi_nonspecific = 1'b0;
        endcase
    end

endmodule

// File: rtl/interrupt_ack_eoi_ctrl.sv
// INTA sequencer and EOI/rotation controller driving the set and clear
// sides of the 8259 in-service register.
module interrupt_ack_eoi_ctrl
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inta_pulse,
    input  logic       mode_8086,
    input  logic       auto_eoi,
    input  logic [7:0] request_vector,
    input  logic [7:0] highest_level_in_service,
    input  logic       write_ocw2,
    input  logic [7:0] ocw2_data,
    output logic [7:0] interrupt,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic [1:0] ack_phase,
    output logic [2:0] ack_level,
    output logic       ack_spurious
);

    ack_state_t state_r, state_nx_s;
    logic [7:0] vec_r, vec_nx_s;
    logic       mode_r, mode_nx_s;
    logic       aeoi_r, aeoi_nx_s;
    logic       rot_aeoi_r, rot_aeoi_nx_s;
    logic [7:0] interrupt_r, interrupt_nx_s;
    logic [7:0] eoi_r, eoi_nx_s;
    logic [2:0] prio_r, prio_nx_s;
    logic [1:0] phase_r, phase_nx_s;
    logic [2:0] level_r, level_nx_s;
    logic       spur_r, spur_nx_s;
    logic       final_s, aeoi_fire_s, aeoi_rotate_s;
    logic [7:0] aeoi_mask_s, ocw_mask_s;

    logic       eoi_nonspecific_s, eoi_specific_s;
    logic       rotate_from_isr_s, rotate_from_level_s;
    logic       rot_aeoi_set_s, rot_aeoi_clr_s;
    logic [2:0] ocw_level_s;

    pic_ocw2_decoder u_ocw2_decoder (
        .write_ocw2        (write_ocw2),
        .ocw2_data         (ocw2_data),
        .eoi_nonspecific   (eoi_nonspecific_s),
        .eoi_specific      (eoi_specific_s),
        .rotate_from_isr   (rotate_from_isr_s),
        .rotate_from_level (rotate_from_level_s),
        .rot_aeoi_set      (rot_aeoi_set_s),
        .rot_aeoi_clr      (rot_aeoi_clr_s),
        .level             (ocw_level_s)
    );

    // INTA sequencing: next state, latched request context and ack status.
    always_comb begin
        state_nx_s     = state_r;
        vec_nx_s       = vec_r;
        mode_nx_s      = mode_r;
        aeoi_nx_s      = aeoi_r;
        interrupt_nx_s = 8'd0;
        phase_nx_s     = phase_r;
        level_nx_s     = level_r;
        spur_nx_s      = spur_r;
        final_s        = 1'b0;
        case (state_r)
            // ACK3 is a one-cycle tail after the third 8080 INTA; a new INTA
            // arriving there starts the next sequence directly.
            ST_IDLE, ST_ACK3: begin
                if (inta_pulse) begin
                    vec_nx_s   = request_vector;
                    mode_nx_s  = mode_8086;
                    aeoi_nx_s  = auto_eoi;
                    state_nx_s = ST_ACK1;
                    phase_nx_s = 2'd1;
                    if (request_vector != 8'd0) begin
                        interrupt_nx_s = request_vector;
                        level_nx_s     = encode8(request_vector);
                        spur_nx_s      = 1'b0;
                    end else begin
                        level_nx_s = SPURIOUS_LEVEL;
                        spur_nx_s  = 1'b1;
                    end
                end else if (state_r == ST_ACK3) begin
                    state_nx_s = ST_IDLE;
                    phase_nx_s = 2'd0;
                    spur_nx_s  = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACK1: begin
                if (inta_pulse) begin
                    if (mode_r) begin
                        final_s    = 1'b1;
                        state_nx_s = ST_IDLE;
                        phase_nx_s = 2'd0;
                        spur_nx_s  = 1'b0;
                    end else begin
                        state_nx_s = ST_ACK2;
                        phase_nx_s = 2'd2;
                    end
                end else begin
                    state_nx_s = ST_ACK1;
                end
            end
            ST_ACK2: begin
                if (inta_pulse) begin
                    final_s    = 1'b1;
                    state_nx_s = ST_ACK3;
                    phase_nx_s = 2'd3;
                end else begin
                    state_nx_s = ST_ACK2;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                phase_nx_s = 2'd0;
            end
        endcase
    end

    // EOI mask merge and priority rotation; an OCW2 rotate overrides AEOI.
    always_comb begin
        aeoi_fire_s   = final_s & aeoi_r & ~spur_r;
        aeoi_rotate_s = aeoi_fire_s & rot_aeoi_r;
        aeoi_mask_s   = aeoi_fire_s ? vec_r : 8'd0;
        if (eoi_nonspecific_s) begin
            ocw_mask_s = highest_level_in_service;
        end else if (eoi_specific_s) begin
            ocw_mask_s = onehot8(ocw_level_s);
        end else begin
            ocw_mask_s = 8'd0;
        end
        eoi_nx_s = ocw_mask_s | aeoi_mask_s;
        if (rotate_from_isr_s && (highest_level_in_service != 8'd0)) begin
            prio_nx_s = encode8(highest_level_in_service);
        end else if (rotate_from_level_s) begin
            prio_nx_s = ocw_level_s;
        end else if (aeoi_rotate_s) begin
            prio_nx_s = level_r;
        end else begin
            prio_nx_s = prio_r;
        end
        if (rot_aeoi_set_s) begin
            rot_aeoi_nx_s = 1'b1;
        end else if (rot_aeoi_clr_s) begin
            rot_aeoi_nx_s = 1'b0;
        end else begin
            rot_aeoi_nx_s = rot_aeoi_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            vec_r       <= 8'd0;
            mode_r      <= 1'b0;
            aeoi_r      <= 1'b0;
            rot_aeoi_r  <= 1'b0;
            interrupt_r <= 8'd0;
            eoi_r       <= 8'd0;
            prio_r      <= PRIORITY_ROTATE_RESET;
            phase_r     <= 2'd0;
            level_r     <= 3'd0;
            spur_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            vec_r       <= vec_nx_s;
            mode_r      <= mode_nx_s;
            aeoi_r      <= aeoi_nx_s;
            rot_aeoi_r  <= rot_aeoi_nx_s;
            interrupt_r <= interrupt_nx_s;
            eoi_r       <= eoi_nx_s;
            prio_r      <= prio_nx_s;
            phase_r     <= phase_nx_s;
            level_r     <= level_nx_s;
            spur_r      <= spur_nx_s;
        end
    end

    assign interrupt        = interrupt_r;
    assign end_of_interrupt = eoi_r;
    assign priority_rotate  = prio_r;
    assign ack_phase        = phase_r;
    assign ack_level        = level_r;
    assign ack_spurious     = spur_r;

endmodule
